// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit adder cut into SEG-bit ripple slices, one register
// stage per slice, valid/ready on both sides. Optional subtract: PIPE_ADDER_SUB_EN.
module pipe_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NST = WIDTH / SEG;

  if ((SEG < 1) || (NST < 1) || (WIDTH % SEG != 0)) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a non-zero multiple of SEG");
  end

  // Index k holds what stage k consumes; index k+1 is what stage k holds.
  logic [NST:0]     v_in;
  logic [NST:0]     c_in;
  logic [WIDTH-1:0] s_in [NST+1];
  logic [WIDTH-1:0] a_in [NST];
  logic [WIDTH-1:0] b_in [NST];
  logic [NST:0]     rdy;
  logic             ovf_q;

  // Subtraction is folded in once at the entry: A + ~B + 1.
`ifdef PIPE_ADDER_SUB_EN
  assign b_in[0] = in_sub ? ~in_b : in_b;
  assign c_in[0] = in_sub | in_cin;
`else
  assign b_in[0] = in_b;
  assign c_in[0] = in_cin;
`endif
  assign a_in[0] = in_a;
  assign v_in[0] = in_valid;
  assign s_in[0] = '0;

  // Ready ripples back from the consumer; an empty stage always accepts.
  always_comb begin
    rdy      = '0;
    rdy[NST] = out_ready;
    for (int k = NST - 1; k >= 0; k--) begin
      rdy[k] = !v_in[k+1] || rdy[k+1];
    end
  end

  for (genvar k = 0; k < NST; k++) begin : g_st
    logic [SEG:0]     slice;
    logic [WIDTH-1:0] s_nxt;
    logic             load;
    logic             v_r;
    logic             c_r;
    logic [WIDTH-1:0] s_r;

    assign load  = rdy[k] && v_in[k];
    assign slice = {1'b0, a_in[k][k*SEG +: SEG]}
                 + {1'b0, b_in[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, c_in[k]};

    // Earlier result slices pass through; slice k gets the new sum.
    always_comb begin
      s_nxt                = s_in[k];
      s_nxt[k*SEG +: SEG]  = slice[SEG-1:0];
    end

    // Valid advances whenever this stage may load, so bubbles collapse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_r <= 1'b0;
      end else if (rdy[k]) begin
        v_r <= v_in[k];
      end
    end

    // Result and carry load only with a real beat; otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        c_r <= 1'b0;
        s_r <= '0;
      end else if (load) begin
        c_r <= slice[SEG];
        s_r <= s_nxt;
      end
    end

    assign v_in[k+1] = v_r;
    assign c_in[k+1] = c_r;
    assign s_in[k+1] = s_r;

    if (k < NST - 1) begin : g_op
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] b_r;

      // Operands ride along for the slices still to be added.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
        end else if (load) begin
          a_r <= a_in[k];
          b_r <= b_in[k];
        end
      end

      assign a_in[k+1] = a_r;
      assign b_in[k+1] = b_r;
    end else begin : g_ovf
      logic msb_cin;

      // Carry into the MSB recovered from the MSB sum bit.
      assign msb_cin = a_in[k][WIDTH-1] ^ b_in[k][WIDTH-1] ^ slice[SEG-1];

      // Signed overflow: carry into MSB differs from carry out of MSB.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (load) begin
          ovf_q <= msb_cin ^ slice[SEG];
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_in[NST];
  assign out_sum   = s_in[NST];
  assign out_cout  = c_in[NST];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: random and directed beats, scoreboard queue of expected
// {ovf,cout,sum}; a monitor pops on every output transfer.
module tb_pipe_adder;

  localparam int W = 16;
  localparam int S = 4;
  localparam int NST = W / S;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_cin = 1'b0;
`ifdef PIPE_ADDER_SUB_EN
  logic          in_sub = 1'b0;
`endif
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;

  int tests = 0;
  int fails = 0;
  logic [W+1:0] sb [$];
  bit rand_rdy = 1'b0;

  pipe_adder #(.WIDTH(W), .SEG(S)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_cin(in_cin),
`ifdef PIPE_ADDER_SUB_EN
    .in_sub(in_sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_cout(out_cout),
    .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the whole word.
  function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W:0]   r;
    logic [W-1:0] bb;
    logic         c;
    logic         ovf;
    bb  = sub ? ~b : b;
    c   = sub ? 1'b1 : cin;
    r   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    ovf = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    return {ovf, r[W], r[W-1:0]};
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
`ifdef PIPE_ADDER_SUB_EN
    in_sub   = sub;
`endif
  endtask

  // Offer one beat, wait (bounded) for acceptance, push its expectation.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub,
                      input logic [W+1:0] exp);
    int n;
    n = 0;
    drive(a, b, cin, sub);
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    else sb.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Empty pipe, out_ready high: result must show NST cycles after accept.
  task automatic lat_check(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic [W+1:0] exp);
    int n;
    drive(a, b, cin, 1'b0);
    @(negedge clk);
    chk("lat_in_ready", 32'(in_ready), 32'd1);
    if (in_ready) sb.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk("latency", 32'(n), 32'(NST));
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare on each output transfer; stalled outputs must hold.
  initial begin
    logic [W+1:0] exp;
    logic [W+1:0] held;
    bit stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_hold", 32'({out_ovf, out_cout, out_sum}), 32'(held));
        end
        stalled = 1'b0;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", 32'({out_ovf, out_cout, out_sum}), 32'hDEAD);
          end else begin
            exp = sb.pop_front();
            chk("sum", 32'(out_sum), 32'(exp[W-1:0]));
            chk("cout", 32'(out_cout), 32'(exp[W]));
            chk("ovf", 32'(out_ovf), 32'(exp[W+1]));
          end
        end else if (out_valid) begin
          held = {out_ovf, out_cout, out_sum};
          stalled = 1'b1;
        end
      end
    end
  end

  // Random backpressure while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         sb_sub;
    int sent;
    int cyc;

    // Reset state
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", 32'({out_ovf, out_cout, out_sum}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed corner cases
    lat_check(16'h0001, 16'h0002, 1'b0, {1'b0, 1'b0, 16'h0003});
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
    send(16'h0000, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b0, 16'h0001});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
    send(16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000});
`ifdef PIPE_ADDER_SUB_EN
    send(16'h0005, 16'h0003, 1'b0, 1'b1, {1'b0, 1'b1, 16'h0002});
    send(16'h0003, 16'h0005, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    send(16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    send(16'h1234, 16'h1234, 1'b0, 1'b0, {1'b0, 1'b0, 16'h2468});
`endif
    drain();

    // Back-to-back stream with a 6-cycle stall at the start
    out_ready = 1'b0;
    sent = 0;
    cyc = 0;
    a = W'($urandom);
    b = W'($urandom);
    c = 1'($urandom);
    drive(a, b, c, 1'b0);
    while (sent < 8 && cyc < 100) begin
      if (cyc == 6) out_ready = 1'b1;
      @(negedge clk);
      if (cyc < 6) chk("stall_in_ready", 32'(in_ready), 32'(sent < NST));
      if (in_ready) begin
        sb.push_back(model(a, b, c, 1'b0));
        sent++;
      end
      @(posedge clk);
      #1;
      if (in_ready || 1'b1) begin
        a = W'($urandom);
        b = W'($urandom);
        c = 1'($urandom);
        drive(a, b, c, 1'b0);
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_sent", 32'(sent), 32'd8);
    out_ready = 1'b1;
    drain();

    // Random beats, random gaps, random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 4) == 0) a = '1;
      c = 1'($urandom);
`ifdef PIPE_ADDER_SUB_EN
      sb_sub = 1'($urandom);
`else
      sb_sub = 1'b0;
`endif
      send(a, b, c, sb_sub, model(a, b, c, sb_sub));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    #1;
    out_ready = 1'b1;
    drain();

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      send(a, b, 1'b0, 1'b0, model(a, b, 1'b0, 1'b0));
    end
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_outputs", 32'({out_ovf, out_cout, out_sum}), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("midrst_hold_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    lat_check(16'hFFFF, 16'h0000, 1'b1, {1'b0, 1'b1, 16'h0000});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
